// File: rtl/axi_llc_lock_gate_if.sv
// Valid/ready descriptor stream between the lock gate and its neighbours.
// The master drives desc/valid, the slave answers with ready.
interface axi_llc_lock_gate_if #(
    parameter int unsigned DescWidth = 20
) ();
    logic [DescWidth-1:0] desc;
    logic                 valid;
    logic                 ready;

    modport master (output desc, output valid, input ready);
    modport slave  (input desc, input valid, output ready);
endinterface

// File: rtl/axi_llc_lock_gate.sv
// Single-entry stage in front of the LLC lock box: holds one descriptor, waits until its line is
// unlocked, pulses the lock request once, then forwards the descriptor. Tracks lock stall cycles.
module axi_llc_lock_gate #(
    parameter int unsigned IndexLength      = 8,
    parameter int unsigned SetAssociativity = 4,
    parameter int unsigned PayloadWidth     = 8,
    parameter int unsigned StallCntWidth    = 16,
    localparam int unsigned LockWidth       = IndexLength + SetAssociativity,
    localparam int unsigned DescWidth       = PayloadWidth + LockWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    axi_llc_lock_gate_if.slave       in_slv,
    axi_llc_lock_gate_if.master      out_mst,
    output logic [LockWidth-1:0]     lock_o,
    input  logic                     locked_i,
    output logic                     lock_req_o,
    output logic [StallCntWidth-1:0] stall_cnt_o,
    output logic [StallCntWidth-1:0] stall_max_o,
    input  logic                     stall_clr_i
);
    // Descriptor layout {payload, index, way_ind}: the low LockWidth bits are the lock payload.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam logic [StallCntWidth-1:0] CntZero = {StallCntWidth{1'b0}};
    localparam logic [StallCntWidth-1:0] CntOne  = {{(StallCntWidth-1){1'b0}}, 1'b1};

    function automatic logic [StallCntWidth-1:0] sat_inc(input logic [StallCntWidth-1:0] v);
        return (&v) ? v : (v + CntOne);
    endfunction

    state_e                   state_q, state_d;
    logic [DescWidth-1:0]     desc_q, desc_d;
    logic [LockWidth-1:0]     lock_q, lock_d;
    logic [StallCntWidth-1:0] stall_cnt_q, stall_cnt_d;
    logic [StallCntWidth-1:0] stall_max_q, stall_max_d;
    logic [StallCntWidth-1:0] cur_stall_q, cur_stall_d;
    logic                     grant_s;
    logic                     stall_s;

    // Next-state and descriptor/lock capture.
    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        lock_d  = lock_q;
        grant_s = 1'b0;
        stall_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_slv.valid) begin
                    desc_d  = in_slv.desc;
                    lock_d  = in_slv.desc[LockWidth-1:0];
                    state_d = ST_LOCK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (!locked_i) begin
                    grant_s = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    stall_s = 1'b1;
                    state_d = ST_LOCK;
                end
            end
            ST_SEND: begin
                if (out_mst.ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall accounting; a clear beats a same-cycle increment but leaves the running stall alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_max_d = stall_max_q;
        cur_stall_d = cur_stall_q;
        if (stall_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
            cur_stall_d = sat_inc(cur_stall_q);
        end else if (grant_s) begin
            cur_stall_d = CntZero;
            if (cur_stall_q > stall_max_q) begin
                stall_max_d = cur_stall_q;
            end else begin
                stall_max_d = stall_max_q;
            end
        end else begin
            cur_stall_d = cur_stall_q;
        end
        if (stall_clr_i) begin
            stall_cnt_d = CntZero;
            stall_max_d = CntZero;
        end else begin
            stall_cnt_d = stall_cnt_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            desc_q      <= {DescWidth{1'b0}};
            lock_q      <= {LockWidth{1'b0}};
            stall_cnt_q <= CntZero;
            stall_max_q <= CntZero;
            cur_stall_q <= CntZero;
        end else begin
            state_q     <= state_d;
            desc_q      <= desc_d;
            lock_q      <= lock_d;
            stall_cnt_q <= stall_cnt_d;
            stall_max_q <= stall_max_d;
            cur_stall_q <= cur_stall_d;
        end
    end

    // Request is combinational on locked_i so a same-cycle unlock is granted immediately.
    assign lock_req_o    = grant_s;
    assign lock_o        = lock_q;
    assign in_slv.ready  = (state_q == ST_IDLE);
    assign out_mst.valid = (state_q == ST_SEND);
    assign out_mst.desc  = desc_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign stall_max_o   = stall_max_q;

    axi_llc_lock_gate_chk #(.DescWidth(DescWidth)) u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lock_state_i (state_q == ST_LOCK),
        .locked_i     (locked_i),
        .lock_req_i   (lock_req_o),
        .in_valid_i   (in_slv.valid),
        .in_ready_i   (in_slv.ready),
        .out_valid_i  (out_mst.valid),
        .out_ready_i  (out_mst.ready),
        .out_desc_i   (out_mst.desc)
    );
endmodule

// Protocol checks for the lock gate: request legality, output stability, one request per descriptor.
module axi_llc_lock_gate_chk #(
    parameter int unsigned DescWidth = 20
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 lock_state_i,
    input logic                 locked_i,
    input logic                 lock_req_i,
    input logic                 in_valid_i,
    input logic                 in_ready_i,
    input logic                 out_valid_i,
    input logic                 out_ready_i,
    input logic [DescWidth-1:0] out_desc_i
);
    logic granted_q;

    // Remembers whether the descriptor currently held has already been granted its lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            granted_q <= 1'b0;
        end else if (in_valid_i && in_ready_i) begin
            granted_q <= 1'b0;
        end else if (lock_req_i) begin
            granted_q <= 1'b1;
        end else begin
            granted_q <= granted_q;
        end
    end

    a_req_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_req_i |-> (lock_state_i && !locked_i));

    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_i && !out_ready_i) |=> (out_valid_i && $stable(out_desc_i)));

    a_single_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_req_i |-> !granted_q);
endmodule

// File: tb/tb_axi_llc_lock_gate.sv
// Self-checking bench for axi_llc_lock_gate: directed vector table, saturation and reset
// sequences, then random traffic against a transaction-level reference model.
module tb_axi_llc_lock_gate;
    localparam int IL = 8;
    localparam int SA = 4;
    localparam int PW = 8;
    localparam int LW = IL + SA;
    localparam int DW = PW + LW;
    localparam int NDESC = 1000;
    localparam int CYC_LIMIT = 40000;
    localparam logic [DW-1:0] D1 = {8'hA5, 8'd5, 4'b0010};
    localparam logic [LW-1:0] L1 = {8'd5, 4'b0010};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    axi_llc_lock_gate_if #(.DescWidth(DW)) in_if ();
    axi_llc_lock_gate_if #(.DescWidth(DW)) out_if ();
    axi_llc_lock_gate_if #(.DescWidth(DW)) in2_if ();
    axi_llc_lock_gate_if #(.DescWidth(DW)) out2_if ();

    logic [LW-1:0] lock, lock2;
    logic          locked, locked2, lock_req, req2, clr, clr2;
    logic [15:0]   cnt, mx;
    logic [1:0]    cnt2, mx2;

    axi_llc_lock_gate #(.IndexLength(IL), .SetAssociativity(SA), .PayloadWidth(PW),
                        .StallCntWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_slv(in_if), .out_mst(out_if),
        .lock_o(lock), .locked_i(locked), .lock_req_o(lock_req),
        .stall_cnt_o(cnt), .stall_max_o(mx), .stall_clr_i(clr));

    axi_llc_lock_gate #(.IndexLength(IL), .SetAssociativity(SA), .PayloadWidth(PW),
                        .StallCntWidth(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_slv(in2_if), .out_mst(out2_if),
        .lock_o(lock2), .locked_i(locked2), .lock_req_o(req2),
        .stall_cnt_o(cnt2), .stall_max_o(mx2), .stall_clr_i(clr2));

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          vld, lck, rdy;
        logic          e_rdy, e_vld, e_req;
        logic [LW-1:0] e_lock;
        int            e_cnt, e_max;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic v, l, r, er, ev, eq, input logic [LW-1:0] el, input int ec, em);
        vec_t t;
        t.vld = v; t.lck = l; t.rdy = r;
        t.e_rdy = er; t.e_vld = ev; t.e_req = eq;
        t.e_lock = el; t.e_cnt = ec; t.e_max = em;
        tbl.push_back(t);
    endtask

    // Reference model state: at most one held descriptor, granted or not.
    bit            held, granted;
    logic [DW-1:0] hd;
    int            tot, mxm, cur;
    logic [DW-1:0] sb[$];
    int            n_acc, n_req, n_out, cyc;

    initial begin
        rst_n = 1'b0;
        in_if.valid = 1'b0; in_if.desc = D1; out_if.ready = 1'b1; locked = 1'b0; clr = 1'b0;
        in2_if.valid = 1'b0; in2_if.desc = D1; out2_if.ready = 1'b0; locked2 = 1'b0; clr2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Uncontended, 7-cycle contention, then 4 cycles of backpressure.
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, L1, 0, 0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, L1, 0, 0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, L1, 0, 0);
        for (int i = 0; i < 7; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, L1, i, 0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, L1, 7, 0);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, L1, 7, 7);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, L1, 7, 7);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, L1, 7, 7);

        foreach (tbl[i]) begin
            @(negedge clk);
            in_if.valid = tbl[i].vld; locked = tbl[i].lck; out_if.ready = tbl[i].rdy;
            #1;
            check("tbl_ready", in_if.ready, tbl[i].e_rdy);
            check("tbl_valid", out_if.valid, tbl[i].e_vld);
            check("tbl_req", lock_req, tbl[i].e_req);
            check("tbl_lock", lock, tbl[i].e_lock);
            check("tbl_cnt", cnt, tbl[i].e_cnt);
            check("tbl_max", mx, tbl[i].e_max);
            if (tbl[i].e_vld) check("tbl_desc", out_if.desc, D1);
        end

        // Saturation with 2-bit counters, then clear.
        @(negedge clk); in2_if.valid = 1'b1; locked2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); in2_if.valid = 1'b0; locked2 = 1'b1;
        end
        @(negedge clk); locked2 = 1'b0; #1;
        check("sat_req", req2, 1'b1);
        check("sat_cnt", cnt2, 2'd3);
        @(negedge clk); out2_if.ready = 1'b1; #1;
        check("sat_valid", out2_if.valid, 1'b1);
        check("sat_max", mx2, 2'd3);
        @(negedge clk); out2_if.ready = 1'b0; clr2 = 1'b1;
        @(negedge clk); clr2 = 1'b0; #1;
        check("clr_cnt", cnt2, 2'd0);
        check("clr_max", mx2, 2'd0);

        // Clear during a stalled cycle wins, but the running stall keeps counting.
        in2_if.valid = 1'b1;
        @(negedge clk); in2_if.valid = 1'b0; locked2 = 1'b1; clr2 = 1'b1;
        @(negedge clk); clr2 = 1'b0; #1;
        check("clrwin_cnt", cnt2, 2'd0);
        @(negedge clk); locked2 = 1'b0; #1;
        check("clrwin_cnt2", cnt2, 2'd1);
        check("clrwin_req", req2, 1'b1);
        @(negedge clk); out2_if.ready = 1'b1; #1;
        check("clrwin_max", mx2, 2'd2);
        @(negedge clk); out2_if.ready = 1'b0;

        // Asynchronous reset while stalled in LOCK.
        in_if.valid = 1'b1; locked = 1'b1; out_if.ready = 1'b1;
        @(negedge clk); in_if.valid = 1'b0;
        @(negedge clk); rst_n = 1'b0; #1;
        check("rst_async_ready", in_if.ready, 1'b1);
        @(negedge clk); rst_n = 1'b1; #1;
        check("rst_ready", in_if.ready, 1'b1);
        check("rst_valid", out_if.valid, 1'b0);
        check("rst_req", lock_req, 1'b0);
        check("rst_cnt", cnt, 16'd0);
        check("rst_max", mx, 16'd0);
        @(negedge clk); locked = 1'b0; #1;
        check("rst_req2", lock_req, 1'b0);
        check("rst_valid2", out_if.valid, 1'b0);

        // Random traffic against the transaction-level model.
        held = 1'b0; granted = 1'b0; hd = '0; tot = 0; mxm = 0; cur = 0;
        n_acc = 0; n_req = 0; n_out = 0; cyc = 0;
        while ((n_acc < NDESC || held) && cyc < CYC_LIMIT) begin
            @(negedge clk);
            cyc++;
            in_if.valid  = (n_acc < NDESC) && ($urandom_range(0, 9) < 6);
            in_if.desc   = DW'($urandom);
            if ($urandom_range(0, 9) < 3) locked = ~locked;
            out_if.ready = ($urandom_range(0, 9) < 7);
            clr          = ($urandom_range(0, 63) == 0);
            #1;
            check("r_ready", in_if.ready, !held);
            check("r_valid", out_if.valid, held && granted);
            check("r_req", lock_req, held && !granted && !locked);
            if (held && !granted) check("r_lock", lock, hd[LW-1:0]);
            if (held && granted) check("r_desc", out_if.desc, hd);
            check("r_cnt", cnt, tot);
            check("r_max", mx, mxm);

            if (lock_req) n_req++;
            if (in_if.valid && in_if.ready) sb.push_back(in_if.desc);
            if (out_if.valid && out_if.ready) begin
                n_out++;
                if (sb.size() == 0) check("order_empty", 32'd1, 32'd0);
                else check("order", out_if.desc, sb.pop_front());
            end

            if (!held) begin
                if (in_if.valid) begin
                    held = 1'b1; granted = 1'b0; hd = in_if.desc; n_acc++;
                end
            end else if (!granted) begin
                if (locked) begin
                    cur = (cur < 65535) ? cur + 1 : 65535;
                    tot = (tot < 65535) ? tot + 1 : 65535;
                end else begin
                    granted = 1'b1;
                    if (cur > mxm) mxm = cur;
                    cur = 0;
                end
            end else if (out_if.ready) begin
                held = 1'b0;
            end
            if (clr) begin
                tot = 0; mxm = 0;
            end
        end
        check("rand_budget", cyc < CYC_LIMIT, 1'b1);
        check("rand_req_count", n_req, n_acc);
        check("rand_out_count", n_out, n_acc);
        check("rand_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
